audio_clk_gen: RTL and testbench
================================

// Module: audio_clk_gen
// PURPOSE
// Parametrised audio serial-clock generator fed by the audio PLL output (refclk).
// Derives BCLK, LRCLK/frame-sync, and one-cycle bit/frame strobes for I2S,
// left-justified or TDM codec links. Sample rate is selectable at run time and
// switches glitch-free on frame boundaries. Gated by the PLL lock indication.
// PARAMETERS
// SLOT_W     32  bits per slot (>=2)
// NUM_SLOTS  2   slots per frame (>=2); 2 = stereo LRCLK, >2 = TDM frame-sync pulse
// LR_FMT     0   0 = I2S (LRCLK/FS leads slot MSB by one BCLK), 1 = left-justified
// DIV0       6   refclk cycles per BCLK for rate_sel=0 (48 kHz at 18.432 MHz, 2x32)
// DIV1       3   rate_sel=1 (96 kHz)
// DIV2       12  rate_sel=2 (24 kHz)
// DIV3       2   rate_sel=3; every DIVn >= 2
// PORTS
// refclk        in   1                  system clock (audio PLL output)
// rst_n         in   1                  async reset, active low
// pll_locked    in   1                  PLL lock, asynchronous to refclk
// enable        in   1                  request clock generation
// rate_sel      in   2                  selects DIV0..DIV3
// bclk          out  1                  bit clock (registered)
// lrclk         out  1                  word select / frame sync (registered)
// bclk_fall_en  out  1                  1-cycle strobe, cycle bclk falls
// bclk_rise_en  out  1                  1-cycle strobe, cycle bclk rises
// frame_start   out  1                  1-cycle strobe, first cycle of frame
// slot_idx      out  $clog2(NUM_SLOTS)  current slot
// bit_idx       out  $clog2(SLOT_W)     current bit, 0 = MSB
// locked        out  1                  synchronised pll_locked
// running       out  1                  state != IDLE
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0, active DIV = DIV0.
// - pll_locked passes a 2-flop synchroniser -> lock_s; locked = lock_s.
// - Counters: div_cnt 0..DIV-1; bit_idx advances when div_cnt wraps;
//   slot_idx advances when bit_idx wraps SLOT_W-1 -> 0; frame = DIV*SLOT_W*NUM_SLOTS cycles.
// - bclk = (div_cnt >= DIV/2) (integer divide); odd DIV -> low 1 cycle less than high.
// - bclk_fall_en = running & div_cnt==0; bclk_rise_en = running & div_cnt==DIV/2.
// - frame_start = running & div_cnt==0 & bit_idx==0 & slot_idx==0.
// - NUM_SLOTS==2: lrclk = 0 for slot 0, 1 for slot 1; LR_FMT=0 changes lrclk one
//   BCLK early (at bit SLOT_W-1 of previous slot); LR_FMT=1 changes at bit 0.
// - NUM_SLOTS>2: lrclk high for exactly one BCLK period: LR_FMT=0 during last bit
//   of last slot; LR_FMT=1 during bit 0 of slot 0.
// - FSM IDLE/RUN/DRAIN:
//   IDLE: counters held 0, bclk=lrclk=0; enable & lock_s -> RUN; active DIV loaded
//     from rate_sel; next cycle is frame_start.
//   RUN: !enable -> DRAIN; !lock_s -> IDLE.
//   DRAIN: completes current frame; last cycle of frame -> IDLE, unless enable
//     high again -> RUN seamlessly (no gap); !lock_s -> IDLE.
// - rate_sel sampled only in last cycle of a frame (or IDLE exit); new DIV from
//   next frame_start. Mid-frame rate_sel changes have no effect on current frame.
// - Lock loss: IDLE on the cycle after lock_s falls; counters cleared, outputs 0;
//   no partial-frame recovery.
// - rst_n mid-operation: immediate return to reset values (asynchronous).
// - enable and lock_s both high in IDLE -> RUN; lock loss has priority over enable.
// TESTING
// - DIV0, 2x32, I2S: frame_start period 384 cycles; 64 fall strobes per frame;
//   bclk 3 low/3 high; lrclk rises 1 BCLK before slot 1 MSB.
// - rate_sel 0->1 at mid-frame: current frame stays 384 cycles, next 192 cycles,
//   no runt bclk pulse.
// - DIV1=3: bclk low 1 cycle, high 2; rise strobe at div_cnt==1.
// - NUM_SLOTS=8, LR_FMT=1: lrclk high 6 cycles at each frame_start, else 0;
//   slot_idx 0..7.
// - enable low at slot 0 bit 5: frame completes, then IDLE, all outputs 0;
//   re-enable during DRAIN -> continuous frames.
// - pll_locked drop mid-frame: running=0 and bclk=0 within 3 cycles; rst_n
//   pulse mid-frame clears all outputs immediately.

Source files
------------

// File: rtl/audio_clk_gen.sv
// Audio serial-clock generator: BCLK, LRCLK/frame-sync and bit/frame strobes
// derived from the audio PLL clock, with run-time rate select and lock gating.
module audio_clk_gen #(
   parameter int SLOT_W    = 32,
   parameter int NUM_SLOTS = 2,
   parameter int LR_FMT    = 0,
   parameter int DIV0      = 6,
   parameter int DIV1      = 3,
   parameter int DIV2      = 12,
   parameter int DIV3      = 2
) (
   input  logic                         refclk,
   input  logic                         rst_n,
   input  logic                         pll_locked,
   input  logic                         enable,
   input  logic [1:0]                   rate_sel,
   output logic                         bclk,
   output logic                         lrclk,
   output logic                         bclk_fall_en,
   output logic                         bclk_rise_en,
   output logic                         frame_start,
   output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
   output logic [$clog2(SLOT_W)-1:0]    bit_idx,
   output logic                         locked,
   output logic                         running
);
   localparam int SW    = $clog2(NUM_SLOTS);
   localparam int BW    = $clog2(SLOT_W);
   localparam int DMAX01 = (DIV0 > DIV1) ? DIV0 : DIV1;
   localparam int DMAX23 = (DIV2 > DIV3) ? DIV2 : DIV3;
   localparam int DMAX  = (DMAX01 > DMAX23) ? DMAX01 : DMAX23;
   localparam int DW    = $clog2(DMAX + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

   state_t          r_state, w_state_nx;
   logic            r_sync1, r_sync2;
   logic [DW-1:0]   r_div, w_div_nx, w_half_nx;
   logic [DW-1:0]   r_div_cnt, w_cnt_nx;
   logic [BW-1:0]   r_bit, w_bit_nx;
   logic [SW-1:0]   r_slot, w_slot_nx;
   logic            r_bclk, r_lrclk, r_fall, r_rise, r_fs, r_running;
   logic            w_last, w_load, w_run_nx, w_lr;

   function automatic logic [DW-1:0] f_div_sel(input logic [1:0] sel);
      case (sel)
         2'd0:    f_div_sel = DW'(DIV0);
         2'd1:    f_div_sel = DW'(DIV1);
         2'd2:    f_div_sel = DW'(DIV2);
         2'd3:    f_div_sel = DW'(DIV3);
         default: f_div_sel = DW'(DIV0);
      endcase
   endfunction

   // Two-flop synchroniser for the asynchronous PLL lock indication.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pll_locked;
         r_sync2 <= r_sync1;
      end
   end

   // Next-state, divider load and counter advance.
   always_comb begin
      w_state_nx = r_state;
      w_load     = 1'b0;
      w_last     = (r_div_cnt == (r_div - DW'(1))) && (r_bit == BW'(SLOT_W - 1)) &&
                   (r_slot == SW'(NUM_SLOTS - 1));
      case (r_state)
         S_IDLE: begin
            if (r_sync2 && enable) begin
               w_state_nx = S_RUN;
               w_load     = 1'b1;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_RUN: begin
            if (!r_sync2) begin
               w_state_nx = S_IDLE;
            end else if (w_last) begin
               w_state_nx = enable ? S_RUN : S_IDLE;
               w_load     = 1'b1;
            end else begin
               w_state_nx = enable ? S_RUN : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!r_sync2) begin
               w_state_nx = S_IDLE;
            end else if (w_last) begin
               w_state_nx = enable ? S_RUN : S_IDLE;
               w_load     = 1'b1;
            end else begin
               w_state_nx = S_DRAIN;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase

      w_div_nx  = w_load ? f_div_sel(rate_sel) : r_div;
      w_run_nx  = (w_state_nx != S_IDLE);
      w_cnt_nx  = r_div_cnt;
      w_bit_nx  = r_bit;
      w_slot_nx = r_slot;
      // Leaving IDLE starts a fresh frame; entering IDLE clears everything.
      if (!w_run_nx || (r_state == S_IDLE)) begin
         w_cnt_nx  = DW'(0);
         w_bit_nx  = BW'(0);
         w_slot_nx = SW'(0);
      end else if (r_div_cnt == (r_div - DW'(1))) begin
         w_cnt_nx = DW'(0);
         if (r_bit == BW'(SLOT_W - 1)) begin
            w_bit_nx  = BW'(0);
            w_slot_nx = (r_slot == SW'(NUM_SLOTS - 1)) ? SW'(0) : (r_slot + SW'(1));
         end else begin
            w_bit_nx = r_bit + BW'(1);
         end
      end else begin
         w_cnt_nx = r_div_cnt + DW'(1);
      end

      w_half_nx = w_div_nx >> 1;
      if (NUM_SLOTS == 2) begin
         if (LR_FMT == 0) begin
            w_lr = w_slot_nx[0] ^ (w_bit_nx == BW'(SLOT_W - 1));
         end else begin
            w_lr = w_slot_nx[0];
         end
      end else begin
         if (LR_FMT == 0) begin
            w_lr = (w_slot_nx == SW'(NUM_SLOTS - 1)) && (w_bit_nx == BW'(SLOT_W - 1));
         end else begin
            w_lr = (w_slot_nx == SW'(0)) && (w_bit_nx == BW'(0));
         end
      end
   end

   // State, counters and registered outputs decoded from the next-cycle values.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_div     <= DW'(DIV0);
         r_div_cnt <= DW'(0);
         r_bit     <= BW'(0);
         r_slot    <= SW'(0);
         r_bclk    <= 1'b0;
         r_lrclk   <= 1'b0;
         r_fall    <= 1'b0;
         r_rise    <= 1'b0;
         r_fs      <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_div     <= w_div_nx;
         r_div_cnt <= w_cnt_nx;
         r_bit     <= w_bit_nx;
         r_slot    <= w_slot_nx;
         r_bclk    <= w_run_nx && (w_cnt_nx >= w_half_nx);
         r_lrclk   <= w_run_nx && w_lr;
         r_fall    <= w_run_nx && (w_cnt_nx == DW'(0));
         r_rise    <= w_run_nx && (w_cnt_nx == w_half_nx);
         r_fs      <= w_run_nx && (w_cnt_nx == DW'(0)) && (w_bit_nx == BW'(0)) &&
                      (w_slot_nx == SW'(0));
         r_running <= w_run_nx;
      end
   end

   assign bclk         = r_bclk;
   assign lrclk        = r_lrclk;
   assign bclk_fall_en = r_fall;
   assign bclk_rise_en = r_rise;
   assign frame_start  = r_fs;
   assign slot_idx     = r_slot;
   assign bit_idx      = r_bit;
   assign locked       = r_sync2;
   assign running      = r_running;
endmodule

// File: tb/tb_audio_clk_gen.sv
// Directed bench for audio_clk_gen: stereo I2S instance plus an 8-slot
// left-justified TDM instance, checked with immediate assertions.
module tb_audio_clk_gen;
   logic       refclk = 1'b0;
   logic       rst_n, pll_locked, enable, en8;
   logic [1:0] rate_sel, rate8;
   logic       bclk, lrclk, fall_en, rise_en, fs, locked, running;
   logic [0:0] slot_idx;
   logic [4:0] bit_idx;
   logic       bclk8, lr8, fall8, rise8, fs8, locked8, running8;
   logic [2:0] slot8;
   logic [1:0] bit8;
   int         n_vec = 0;
   int         n_err = 0;

   always #5 refclk = ~refclk;

   audio_clk_gen dut (
      .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .enable(enable),
      .rate_sel(rate_sel), .bclk(bclk), .lrclk(lrclk), .bclk_fall_en(fall_en),
      .bclk_rise_en(rise_en), .frame_start(fs), .slot_idx(slot_idx), .bit_idx(bit_idx),
      .locked(locked), .running(running));

   audio_clk_gen #(.SLOT_W(4), .NUM_SLOTS(8), .LR_FMT(1)) dut8 (
      .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .enable(en8),
      .rate_sel(rate8), .bclk(bclk8), .lrclk(lr8), .bclk_fall_en(fall8),
      .bclk_rise_en(rise8), .frame_start(fs8), .slot_idx(slot8), .bit_idx(bit8),
      .locked(locked8), .running(running8));

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge refclk);
   endtask

   // Walk one frame of the stereo instance starting on its frame_start cycle.
   task automatic frame_stats(input int chg_at, input logic [1:0] chg_val,
                              output int len, output int falls, output int rises,
                              output int lo_min, output int hi_min,
                              output int lr_up, output int lr_dn);
      int   run;
      logic lvl, plr;
      len = 0; falls = 0; rises = 0; lo_min = 999; hi_min = 999; lr_up = -1; lr_dn = -1;
      lvl = bclk; run = 0; plr = lrclk;
      do begin
         if (len == chg_at) rate_sel = chg_val;
         falls += int'(fall_en);
         rises += int'(rise_en);
         if (bclk != lvl) begin
            if (lvl) hi_min = (run < hi_min) ? run : hi_min;
            else     lo_min = (run < lo_min) ? run : lo_min;
            lvl = bclk; run = 0;
         end
         run++;
         if (lrclk && !plr) lr_up = len;
         if (!lrclk && plr) lr_dn = len;
         plr = lrclk;
         @(negedge refclk);
         len++;
      end while (!fs && len < 4000);
      if (bclk != lvl) begin
         if (lvl) hi_min = (run < hi_min) ? run : hi_min;
         else     lo_min = (run < lo_min) ? run : lo_min;
      end
   endtask

   task automatic wait_fs(output int n, output int gaps);
      n = 0; gaps = 0;
      do begin
         @(negedge refclk);
         n++;
         if (!running) gaps++;
      end while (!fs && n < 4000);
   endtask

   initial begin
      int len, falls, rises, lo_min, hi_min, lr_up, lr_dn, n, gaps, k;
      int bad, hi, maxs, extra;
      rst_n = 1'b0; pll_locked = 1'b0; enable = 1'b0; en8 = 1'b0;
      rate_sel = 2'd0; rate8 = 2'd0;
      tick(3);
      chk("rst_bclk", bclk, 0);
      chk("rst_lrclk", lrclk, 0);
      chk("rst_running", running, 0);
      chk("rst_fs", fs, 0);
      chk("rst_locked", locked, 0);
      chk("rst_bit", bit_idx, 0);

      rst_n = 1'b1; pll_locked = 1'b1;
      tick(1);
      chk("lock_sync_1", locked, 0);
      tick(1);
      chk("lock_sync_2", locked, 1);
      chk("idle_running", running, 0);

      enable = 1'b1;
      tick(1);
      chk("start_fs", fs, 1);
      chk("start_running", running, 1);
      chk("start_bclk", bclk, 0);
      chk("start_fall", fall_en, 1);

      frame_stats(-1, 2'd0, len, falls, rises, lo_min, hi_min, lr_up, lr_dn);
      chk("f1_len", len, 384);
      chk("f1_falls", falls, 64);
      chk("f1_rises", rises, 64);
      chk("f1_lo", lo_min, 3);
      chk("f1_hi", hi_min, 3);
      chk("f1_lr_up", lr_up, 186);
      chk("f1_lr_dn", lr_dn, 378);

      frame_stats(190, 2'd1, len, falls, rises, lo_min, hi_min, lr_up, lr_dn);
      chk("f2_len", len, 384);
      chk("f2_lo", lo_min, 3);
      chk("f2_hi", hi_min, 3);

      frame_stats(-1, 2'd1, len, falls, rises, lo_min, hi_min, lr_up, lr_dn);
      chk("f3_len", len, 192);
      chk("f3_falls", falls, 64);
      chk("f3_lo", lo_min, 1);
      chk("f3_hi", hi_min, 2);
      chk("f3_lr_up", lr_up, 93);

      tick(15);
      chk("drain_bit", bit_idx, 5);
      chk("drain_slot", slot_idx, 0);
      enable = 1'b0;
      k = 0;
      while (running && k < 1000) begin
         if (fs) k = k + 2000;
         tick(1);
         k++;
      end
      chk("drain_len", k, 177);
      chk("drain_bclk", bclk, 0);
      chk("drain_lrclk", lrclk, 0);
      chk("drain_fs", fs, 0);
      chk("drain_bit0", bit_idx, 0);
      chk("drain_locked", locked, 1);

      enable = 1'b1;
      tick(1);
      chk("restart_fs", fs, 1);
      tick(10);
      enable = 1'b0;
      tick(50);
      enable = 1'b1;
      wait_fs(n, gaps);
      chk("redrain_len", n, 132);
      chk("redrain_gaps", gaps, 0);
      frame_stats(-1, 2'd1, len, falls, rises, lo_min, hi_min, lr_up, lr_dn);
      chk("redrain_next_len", len, 192);

      tick(20);
      pll_locked = 1'b0;
      tick(2);
      chk("lockloss_locked", locked, 0);
      chk("lockloss_run_still", running, 1);
      tick(1);
      chk("lockloss_running", running, 0);
      chk("lockloss_bclk", bclk, 0);
      chk("lockloss_bit", bit_idx, 0);

      pll_locked = 1'b1;
      tick(3);
      chk("relock_fs", fs, 1);
      tick(40);
      chk("pre_rst_running", running, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_running", running, 0);
      chk("arst_bclk", bclk, 0);
      chk("arst_locked", locked, 0);
      chk("arst_bit", bit_idx, 0);
      @(negedge refclk);
      rst_n = 1'b1; enable = 1'b0; en8 = 1'b1;

      k = 0;
      while (!fs8 && k < 50) begin
         tick(1);
         k++;
      end
      chk("tdm_fs_seen", fs8, 1);
      bad = 0; hi = 0; maxs = 0; extra = 0;
      for (int i = 0; i < 192; i++) begin
         if (lr8 !== (i < 6)) bad++;
         if (lr8) hi++;
         if (int'(slot8) > maxs) maxs = int'(slot8);
         if (i > 0 && fs8) extra++;
         tick(1);
      end
      chk("tdm_lr_hi", hi, 6);
      chk("tdm_lr_bad", bad, 0);
      chk("tdm_max_slot", maxs, 7);
      chk("tdm_extra_fs", extra, 0);
      chk("tdm_period", fs8, 1);
      chk("tdm_main_idle", running, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
